// File: rtl/reset_sequencer_pkg.sv
// reset_pkg: shared types for the reset sequencer.
//   rst_cause_t  - encoding of the last reset cause reported to the command interface.
//   rseq_state_t - sequencer FSM states.
//   cnt_width()  - bits needed for a counter whose largest value is 'term'.
package reset_pkg;

    typedef enum logic [1:0] {
        RST_POR = 2'd0,
        RST_BTN = 2'd1,
        RST_WDT = 2'd2,
        RST_SW  = 2'd3
    } rst_cause_t;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_GAP    = 2'd1,
        ST_IDLE   = 2'd2
    } rseq_state_t;

    // A counter that must hold the value 'term' needs clog2(term+1) bits.
    function automatic int cnt_width(input int term);
        return (term <= 1) ? 1 : $clog2(term + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: request inputs and reset outputs of the reset sequencer.
//   btn_n     - raw async push-button, active-low
//   sw_req    - software reset request
//   wdt_en    - watchdog enable
//   wdt_kick  - watchdog kick
//   ext_rst_n - external SPI device reset, active-low
//   core_rst  - core logic reset, active-high
//   busy      - sequence in progress (state not IDLE)
//   cause     - cause of the last reset
//   state     - FSM state, exported for observation
// Signalling: there is no valid/ready pairing here. sw_req and wdt_kick are
// single-cycle pulses acted on at the clock edge that samples them and need no
// acknowledge; btn_n and wdt_en are levels. All outputs change only on clk.
// master = requester side (drives requests), slave = the sequencer.
interface reset_sequencer_if;
    import reset_pkg::*;

    logic        btn_n;
    logic        sw_req;
    logic        wdt_en;
    logic        wdt_kick;
    logic        ext_rst_n;
    logic        core_rst;
    logic        busy;
    rst_cause_t  cause;
    rseq_state_t state;

    modport master (
        output btn_n, sw_req, wdt_en, wdt_kick,
        input  ext_rst_n, core_rst, busy, cause, state
    );

    modport slave (
        input  btn_n, sw_req, wdt_en, wdt_kick,
        output ext_rst_n, core_rst, busy, cause, state
    );
endinterface

// File: rtl/reset_sequencer_btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus debounce for an active-low button.
//   clk, rst - system clock, synchronous active-high reset
//   btn_n    - raw asynchronous button, active-low
//   press    - registered one-cycle event, high in the cycle the consecutive
//              low count reaches DEBOUNCE
module btn_debounce
    import reset_pkg::*;
#(
    parameter int DEBOUNCE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);
    localparam int CW = cnt_width(DEBOUNCE);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] low_cnt;

    // The count saturates at DEBOUNCE, so 'press' can only fire once per hold;
    // a single high sample clears it and re-arms detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            low_cnt <= '0;
            press   <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            if (!sync2) begin
                if (low_cnt != CW'(DEBOUNCE))
                    low_cnt <= low_cnt + CW'(1);
                press <= (low_cnt == CW'(DEBOUNCE - 1));
            end else begin
                low_cnt <= '0;
                press   <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: collects button, watchdog and software reset requests and
// sequences a stretched ext_rst_n (active-low) followed by core_rst release.
//   clk, rst - system clock, synchronous active-high reset
//   bus      - reset_sequencer_if.slave: requests in; ext_rst_n, core_rst,
//              busy, cause, state out
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int RELEASE_GAP = 4,
    parameter int DEBOUNCE    = 8,
    parameter int WDT_CYCLES  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    reset_sequencer_if.slave    bus
);
    // One hold counter serves both ASSERT and GAP, so size it for the longer.
    localparam int HOLD_TERM = (HOLD_CYCLES > RELEASE_GAP) ? HOLD_CYCLES - 1 : RELEASE_GAP - 1;
    localparam int HW = cnt_width(HOLD_TERM);
    localparam int WW = cnt_width(WDT_CYCLES - 1);

    rseq_state_t   state;
    rseq_state_t   state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic [WW-1:0] wdt_cnt;
    logic          ext_rst_n_q;
    logic          core_rst_q;
    rst_cause_t    cause_q;
    rst_cause_t    cause_nxt;
    logic          btn_evt;
    logic          wdt_expire;
    logic          trigger;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn_n (bus.btn_n),
        .press (btn_evt)
    );

    // A kick on the terminal-count cycle suppresses expiry.
    assign wdt_expire = bus.wdt_en && (state == ST_IDLE) && !bus.wdt_kick &&
                        (wdt_cnt == WW'(WDT_CYCLES - 1));
    assign trigger    = btn_evt || wdt_expire || bus.sw_req;

    always_comb begin
        cause_nxt = cause_q;
        if (btn_evt)
            cause_nxt = RST_BTN;
        else if (wdt_expire)
            cause_nxt = RST_WDT;
        else if (bus.sw_req)
            cause_nxt = RST_SW;
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt + HW'(1);
        if (trigger) begin
            // Any trigger restarts the full hold, including from GAP.
            state_nxt = ST_ASSERT;
            hold_nxt  = '0;
        end else begin
            case (state)
                ST_ASSERT: if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                    state_nxt = ST_GAP;
                    hold_nxt  = '0;
                end
                ST_GAP: if (hold_cnt == HW'(RELEASE_GAP - 1)) begin
                    state_nxt = ST_IDLE;
                    hold_nxt  = '0;
                end
                ST_IDLE: hold_nxt = '0;
                default: begin
                    state_nxt = ST_ASSERT;
                    hold_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ASSERT;
            hold_cnt    <= '0;
            ext_rst_n_q <= 1'b0;
            core_rst_q  <= 1'b1;
            cause_q     <= RST_POR;
            wdt_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            // Reset outputs are decoded from the next state so they change
            // together with the state register.
            ext_rst_n_q <= (state_nxt != ST_ASSERT);
            core_rst_q  <= (state_nxt != ST_IDLE);
            cause_q     <= cause_nxt;
            if (!bus.wdt_en || (state != ST_IDLE) || bus.wdt_kick || wdt_expire)
                wdt_cnt <= '0;
            else
                wdt_cnt <= wdt_cnt + WW'(1);
        end
    end

    assign bus.ext_rst_n = ext_rst_n_q;
    assign bus.core_rst  = core_rst_q;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.cause     = cause_q;
    assign bus.state     = state;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer. A cycle model tracks "cycles since the last
// sequence start" and derives all outputs from it; a compare process checks
// the DUT against it every cycle, and directed literal checks pin key timing.
module tb_reset_sequencer;
    import reset_pkg::*;

    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int DEB  = 8;
    localparam int WDT  = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reset_sequencer_if bus ();

    reset_sequencer #(
        .HOLD_CYCLES (HOLD),
        .RELEASE_GAP (GAP),
        .DEBOUNCE    (DEB),
        .WDT_CYCLES  (WDT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_since;      // cycles since the last sequence start
    logic [1:0] m_cause;
    logic       btn_q[$];     // raw button samples, newest first
    int         low_run;      // consecutive synchronized-low samples
    logic       btn_pending;  // debounced press seen by the sequencer next edge
    int         wdt_run;      // eligible idle cycles without a kick
    logic [6:0] exp_q[$];     // {ext_rst_n, core_rst, busy, cause, state}

    always @(posedge clk) begin : model
        logic       sync_now, btn_t, wdt_t, sw_t, idle;
        logic [1:0] st;
        if (rst) begin
            m_since     = 0;
            m_cause     = 2'd0;
            btn_q       = {1'b1, 1'b1};
            low_run     = 0;
            btn_pending = 1'b0;
            wdt_run     = 0;
        end else begin
            sync_now = btn_q[1];
            btn_t    = btn_pending;
            sw_t     = bus.sw_req;
            idle     = (m_since >= HOLD + GAP);
            wdt_t    = bus.wdt_en && idle && !bus.wdt_kick && (wdt_run == WDT - 1);
            if (!sync_now) begin
                btn_pending = (low_run == DEB - 1);
                low_run++;
            end else begin
                btn_pending = 1'b0;
                low_run     = 0;
            end
            btn_q.push_front(bus.btn_n);
            void'(btn_q.pop_back());
            wdt_run = (bus.wdt_en && idle && !bus.wdt_kick && !wdt_t) ? wdt_run + 1 : 0;
            if (btn_t || wdt_t || sw_t) begin
                m_since = 0;
                m_cause = btn_t ? 2'd1 : (wdt_t ? 2'd2 : 2'd3);
            end else if (m_since < 100000) begin
                m_since++;
            end
        end
        st = (m_since < HOLD) ? ST_ASSERT : ((m_since < HOLD + GAP) ? ST_GAP : ST_IDLE);
        exp_q.push_back({m_since >= HOLD, m_since < HOLD + GAP, m_since < HOLD + GAP, m_cause, st});
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin : compare
        logic [6:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ext_rst_n", 32'(bus.ext_rst_n), 32'(e[6]));
            check("core_rst",  32'(bus.core_rst),  32'(e[5]));
            check("busy",      32'(bus.busy),      32'(e[4]));
            check("cause",     32'(bus.cause),     32'(e[3:2]));
            check("state",     32'(bus.state),     32'(e[1:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sw_pulse();
        bus.sw_req = 1'b1;
        tick(1);
        bus.sw_req = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
    endtask

    initial begin : timeout
        #2000000;
        bad++;
        $display("FAIL timeout: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        bus.btn_n    = 1'b1;
        bus.sw_req   = 1'b0;
        bus.wdt_en   = 1'b0;
        bus.wdt_kick = 1'b0;

        // POR: rst high for 3 edges; the last of them is edge 0.
        tick(3);
        rst = 1'b0;
        lit("por_ext_low",  32'(bus.ext_rst_n), 0);
        lit("por_core_hi",  32'(bus.core_rst), 1);
        lit("por_busy",     32'(bus.busy), 1);
        lit("por_cause",    32'(bus.cause), 0);
        tick(15);
        lit("por_ext_e15",  32'(bus.ext_rst_n), 0);
        tick(1);
        lit("por_ext_e16",  32'(bus.ext_rst_n), 1);
        lit("por_core_e16", 32'(bus.core_rst), 1);
        tick(3);
        lit("por_core_e19", 32'(bus.core_rst), 1);
        tick(1);
        lit("por_core_e20", 32'(bus.core_rst), 0);
        lit("por_busy_e20", 32'(bus.busy), 0);
        tick(5);

        // Short button press: 7 low samples, no event.
        bus.btn_n = 1'b0;
        tick(7);
        bus.btn_n = 1'b1;
        tick(20);
        lit("btn_short_ext",   32'(bus.ext_rst_n), 1);
        lit("btn_short_cause", 32'(bus.cause), 0);

        // Long press: reset 11 cycles after the first low, exactly once.
        bus.btn_n = 1'b0;
        tick(10);
        lit("btn_ext_e10", 32'(bus.ext_rst_n), 1);
        tick(1);
        lit("btn_ext_e11", 32'(bus.ext_rst_n), 0);
        lit("btn_cause",   32'(bus.cause), 1);
        tick(29);
        bus.btn_n = 1'b1;
        tick(40);
        lit("btn_once_core", 32'(bus.core_rst), 0);

        // Software request in the 2nd GAP cycle restarts the full sequence.
        sw_pulse();
        tick(17);
        lit("gap2_state", 32'(bus.state), 32'(ST_GAP));
        sw_pulse();
        lit("regap_ext",   32'(bus.ext_rst_n), 0);
        lit("regap_cause", 32'(bus.cause), 3);
        tick(15);
        lit("regap_ext_e15", 32'(bus.ext_rst_n), 0);
        tick(1);
        lit("regap_ext_e16", 32'(bus.ext_rst_n), 1);
        tick(4);
        lit("regap_core_e20", 32'(bus.core_rst), 0);
        tick(5);

        // Software request mid-ASSERT extends the hold.
        sw_pulse();
        tick(7);
        sw_pulse();
        tick(15);
        lit("reassert_ext_e15", 32'(bus.ext_rst_n), 0);
        tick(1);
        lit("reassert_ext_e16", 32'(bus.ext_rst_n), 1);
        tick(30);

        // Button event and sw_req on the same edge: one sequence, cause BTN.
        bus.btn_n = 1'b0;
        tick(10);
        bus.sw_req = 1'b1;
        tick(1);
        bus.sw_req = 1'b0;
        lit("simul_cause", 32'(bus.cause), 1);
        lit("simul_ext",   32'(bus.ext_rst_n), 0);
        tick(10);
        bus.btn_n = 1'b1;
        tick(40);

        // rst pulsed during GAP.
        sw_pulse();
        tick(17);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        lit("midrst_ext",   32'(bus.ext_rst_n), 0);
        lit("midrst_cause", 32'(bus.cause), 0);
        tick(15);
        lit("midrst_ext_e15", 32'(bus.ext_rst_n), 0);
        tick(1);
        lit("midrst_ext_e16", 32'(bus.ext_rst_n), 1);
        tick(30);

        // Watchdog expiry with no kicks.
        bus.wdt_en = 1'b1;
        tick(1023);
        lit("wdt_ext_e1023", 32'(bus.ext_rst_n), 1);
        tick(1);
        lit("wdt_ext_e1024", 32'(bus.ext_rst_n), 0);
        lit("wdt_cause",     32'(bus.cause), 2);
        bus.wdt_en = 1'b0;
        tick(30);

        // Kicks every 1000 cycles, then a kick on the terminal count.
        bus.wdt_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(999);
            bus.wdt_kick = 1'b1;
            tick(1);
            bus.wdt_kick = 1'b0;
        end
        tick(1023);
        bus.wdt_kick = 1'b1;
        tick(1);
        bus.wdt_kick = 1'b0;
        lit("kick_term_ext", 32'(bus.ext_rst_n), 1);
        tick(50);
        lit("kick_term_busy",  32'(bus.busy), 0);
        lit("kick_term_cause", 32'(bus.cause), 2);
        bus.wdt_en = 1'b0;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Synchronous reset generator and sequencer for the SPI FPGA design. It collects reset requests from a debounced push-button, a software command, and an internal watchdog. It drives a stretched, active-low reset to the external SPI device and an active-high reset to the core logic, releasing them in a fixed order. It sits downstream of the board reset synchronizer and records the cause of the last reset for the command interface to read.

## Interface
- `HOLD_CYCLES`, 16: cycles both resets stay asserted after the last trigger (≥2).
- `RELEASE_GAP`, 4: cycles between `ext_rst_n` release and `core_rst` release (≥1).
- `DEBOUNCE`, 8: consecutive synchronized-low samples needed to accept a button press (≥2).
- `WDT_CYCLES`, 1024: watchdog timeout in cycles without a kick (≥4).

- `clk`  in  1: single system clock; all logic in this domain.
- `rst`  in  1: reset, synchronous, active-high; sampled only on `posedge clk`.
- `btn_n`  in  1: raw asynchronous push-button, active-low; synchronized internally by 2 flops.
- `sw_req`  in  1: one-cycle software reset request.
- `wdt_en`  in  1: watchdog enable; when 0, the watchdog counter is held at 0.
- `wdt_kick`  in  1: one-cycle pulse that clears the watchdog counter.
- `ext_rst_n`  out  1: reset to the external SPI device, active-low, registered.
- `core_rst`  out  1: reset to core logic, active-high, registered.
- `busy`  out  1: high whenever the state is not IDLE.
- `cause`  out  2: cause of the last reset. 0 = POR, 1 = BTN, 2 = WDT, 3 = SW.

## Operation
- FSM states:
  - ASSERT: `ext_rst_n` = 0, `core_rst` = 1.
  - GAP: `ext_rst_n` = 1, `core_rst` = 1.
  - IDLE: `ext_rst_n` = 1, `core_rst` = 0.
- Reset values while `rst` = 1:
  - state ASSERT, hold counter 0, `ext_rst_n` = 0, `core_rst` = 1, `busy` = 1, `cause` = 0.
  - Debounce counter 0, watchdog counter 0, button synchronizer flops = 1.
- ASSERT: the hold counter increments each cycle. At `HOLD_CYCLES-1` the FSM moves to GAP and the counter clears.
- GAP: the counter increments. At `RELEASE_GAP-1` the FSM moves to IDLE.
- Trigger = button event, watchdog expiry, or `sw_req`.
  - A trigger in any state forces ASSERT and clears the counter. In ASSERT this restarts the hold time; in GAP it re-asserts `ext_rst_n`.
  - `cause` updates on every trigger and holds its value otherwise.
- Simultaneous triggers: priority is BTN > WDT > SW for `cause`. Only one sequence runs.
- Button debounce:
  - The counter counts consecutive synchronized-low cycles and saturates at `DEBOUNCE`.
  - A button event fires once, in the cycle the count reaches `DEBOUNCE`.
  - Any high sample clears the counter and re-arms detection. Holding the button produces exactly one event.
- Watchdog:
  - The counter increments while `wdt_en` = 1, the state is IDLE, and `wdt_kick` = 0.
  - Expiry fires in the cycle the count reaches `WDT_CYCLES-1`. The counter then clears.
  - The counter is held at 0 outside IDLE, so it cannot expire while a reset is in progress.
  - `wdt_kick` in the same cycle as reaching the terminal count wins: counter clears, no expiry.
- Counter widths: `$clog2` of the respective parameter, plus 1 bit where the terminal count equals the parameter.

## Timing
- All outputs are registered, so trigger-to-output latency is 1 cycle. A trigger sampled at edge N gives `ext_rst_n` = 0 after edge N.
- After `rst` falls at edge R:
  - `ext_rst_n` stays 0 for exactly `HOLD_CYCLES` cycles, rising after edge R+`HOLD_CYCLES`.
  - `core_rst` falls `RELEASE_GAP` cycles after that.
- Button path latency, from the first low on `btn_n` to `ext_rst_n` = 0: 2 (sync) + `DEBOUNCE` + 1 cycles.
- `busy` is combinational from the state register and is high for `HOLD_CYCLES + RELEASE_GAP` cycles per uninterrupted sequence.
- `rst` asserted mid-sequence returns the block to the reset values on the next edge. `cause` becomes POR.

## Structure
- Shared package `reset_pkg`:
  - `typedef enum logic [1:0] {RST_POR, RST_BTN, RST_WDT, RST_SW} rst_cause_t`.
  - The FSM state enum `rseq_state_t`.
- Sub-module `btn_debounce`: 2-flop synchronizer, saturating counter, and single-event output (parameter `DEBOUNCE`).
- The FSM, hold counter, watchdog, and cause register live in `reset_sequencer`.

## Test plan
All scenarios use defaults HOLD=16, GAP=4, DEBOUNCE=8, WDT=1024.

- **POR:** `rst` high 3 cycles, then low → `ext_rst_n` rises on cycle 16 after release, `core_rst` falls on cycle 20, `cause` = 0, `busy` drops with `core_rst`.
- **Button:**
  - `btn_n` low for 7 cycles, then high → no sequence.
  - `btn_n` low for 40 cycles → exactly one sequence; `ext_rst_n` falls 11 cycles after the first low; `cause` = 1.
- **Watchdog:** `wdt_en` = 1 with no kick → expiry at count 1023, sequence runs, `cause` = 2. Kicking every 1000 cycles → never fires. A kick coincident with terminal count → no reset.
- **Retrigger:** `sw_req` in the 2nd GAP cycle → `ext_rst_n` goes back to 0 next cycle and a full 16+4 sequence restarts, `cause` = 3. `sw_req` mid-ASSERT → hold extends to 16 cycles from the request.
- **Simultaneous:** button event and `sw_req` in the same cycle → one sequence, `cause` = 1.
- **Reset mid-sequence:** `rst` pulsed during GAP → next cycle `ext_rst_n` = 0, `cause` = 0, hold counter restarts from 0.
